// File: rtl/adder_result_stage.sv
// ============================================================================
// Module   : adder_result_stage
// Brief    : Registered result stage after the 32-bit adders: derives N/Z/C/V,
//            buffers results in a 2-entry skid buffer with valid/ready, and
//            keeps a saturating overflow count. Optional parity storage is
//            enabled by defining ADDER_RESULT_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags,
  output logic             out_parity,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_sum_q,   head_sum_d;
  logic [3:0]       head_flags_q, head_flags_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_sum_q,   skid_sum_d;
  logic [3:0]       skid_flags_q, skid_flags_d;
  logic             in_ready_q,   in_ready_d;
  logic [CNT_W-1:0] ovf_cnt_q,    ovf_cnt_d;

  logic             w_accept;
  logic             w_pop;
  logic             w_head_load;
  logic [3:0]       w_in_flags;

  assign w_accept    = in_valid && in_ready_q;
  assign w_pop       = head_valid_q && out_ready;
  assign w_head_load = !head_valid_q || w_pop;

  // Flags are frozen at accept time and travel with the sum.
  assign w_in_flags = {in_sum[WIDTH-1],
                       (in_sum == '0),
                       in_cout,
                       (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb)};

  always_comb begin
    head_valid_d = head_valid_q;
    head_sum_d   = head_sum_q;
    head_flags_d = head_flags_q;
    skid_valid_d = skid_valid_q;
    skid_sum_d   = skid_sum_q;
    skid_flags_d = skid_flags_q;
    if (w_head_load) begin
      // in_ready is low whenever the skid holds a beat, so no accept collides here.
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_sum_d   = skid_sum_q;
        head_flags_d = skid_flags_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        head_valid_d = 1'b1;
        head_sum_d   = in_sum;
        head_flags_d = w_in_flags;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_sum_d   = in_sum;
      skid_flags_d = w_in_flags;
    end
  end

  assign in_ready_d = !skid_valid_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (cnt_clr) begin
      ovf_cnt_d = '0;
    end else if (w_accept && w_in_flags[0] && (ovf_cnt_q != c_CNT_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      head_sum_q   <= '0;
      head_flags_q <= '0;
      skid_valid_q <= 1'b0;
      skid_sum_q   <= '0;
      skid_flags_q <= '0;
      in_ready_q   <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_sum_q   <= head_sum_d;
      head_flags_q <= head_flags_d;
      skid_valid_q <= skid_valid_d;
      skid_sum_q   <= skid_sum_d;
      skid_flags_q <= skid_flags_d;
      in_ready_q   <= in_ready_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

`ifdef ADDER_RESULT_PARITY_EN
  logic head_par_q, head_par_d;
  logic skid_par_q, skid_par_d;

  always_comb begin
    head_par_d = head_par_q;
    skid_par_d = skid_par_q;
    if (w_head_load) begin
      if (skid_valid_q) begin
        head_par_d = skid_par_q;
      end else if (w_accept) begin
        head_par_d = ^in_sum;
      end
    end else if (w_accept) begin
      skid_par_d = ^in_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_par_q <= 1'b0;
      skid_par_q <= 1'b0;
    end else begin
      head_par_q <= head_par_d;
      skid_par_q <= skid_par_d;
    end
  end

  assign out_parity = head_par_q;
`else
  assign out_parity = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = head_valid_q;
  assign out_sum   = head_sum_q;
  assign out_flags = head_flags_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

`default_nettype wire
